// File: rtl/cpu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer_if
//  Description : Bundle of the memory bus and datapath control signals that
//                connect the CPU sequencer to memory and the register-file /
//                ALU datapath.
//                master : the sequencer (drives strobes, address, status)
//                slave  : memory + datapath side (drives start_pc, mem_rdata,
//                         dp_out)
//  Ports       : start_pc[7:0], mem_rdata[15:0], dp_out[15:0]  (into master)
//                mem_addr[7:0], mem_rd, mem_wr, rnum[2:0], vsel[1:0],
//                write, loada, loadb, loadc, loads, asel, bsel,
//                alu_op[1:0], shift[1:0], sximm8[15:0], sximm5[15:0],
//                pc[7:0], halted, illegal                  (out of master)
//  Revision    : 1.0  initial release
// ============================================================================
interface cpu_sequencer_if;
   logic [7:0]  start_pc;
   logic [15:0] mem_rdata;
   logic [15:0] dp_out;
   logic [7:0]  mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [2:0]  rnum;
   logic [1:0]  vsel;
   logic        write;
   logic        loada;
   logic        loadb;
   logic        loadc;
   logic        loads;
   logic        asel;
   logic        bsel;
   logic [1:0]  alu_op;
   logic [1:0]  shift;
   logic [15:0] sximm8;
   logic [15:0] sximm5;
   logic [7:0]  pc;
   logic        halted;
   logic        illegal;

   modport master (
      input  start_pc, mem_rdata, dp_out,
      output mem_addr, mem_rd, mem_wr, rnum, vsel, write, loada, loadb,
             loadc, loads, asel, bsel, alu_op, shift, sximm8, sximm5, pc,
             halted, illegal
   );

   modport slave (
      output start_pc, mem_rdata, dp_out,
      input  mem_addr, mem_rd, mem_wr, rnum, vsel, write, loada, loadb,
             loadc, loads, asel, bsel, alu_op, shift, sximm8, sximm5, pc,
             halted, illegal
   );
endinterface
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer
//  Description : Fetch/decode/execute controller for the 16-bit simple RISC
//                CPU. Owns the program counter and instruction register,
//                shares the single-port 256x16 memory between instruction
//                fetch and LDR/STR, and sequences the datapath strobes one
//                state per cycle until HALT retires.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous active-high reset
//                bus  - cpu_sequencer_if.master (memory bus, datapath
//                       strobes, immediates, pc and status flags)
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_sequencer (
   input  logic                  clk,
   input  logic                  rst,
   cpu_sequencer_if.master       bus
);

   typedef enum logic [3:0] {
      S_RST    = 4'd0,
      S_FETCH  = 4'd1,
      S_LOADIR = 4'd2,
      S_DECODE = 4'd3,
      S_WRIMM  = 4'd4,
      S_RDA    = 4'd5,
      S_RDB    = 4'd6,
      S_EXEC   = 4'd7,
      S_WB     = 4'd8,
      S_MEM    = 4'd9,
      S_WBM    = 4'd10,
      S_ADDR   = 4'd11,
      S_RDD    = 4'd12,
      S_PASS   = 4'd13,
      S_STORE  = 4'd14,
      S_HALT   = 4'd15
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_pc;
   logic [15:0] r_ir;
   logic [7:0]  r_dar;
   logic        r_illegal;

   // Instruction fields
   logic [2:0] w_opc;
   logic [1:0] w_op;
   logic [2:0] w_rn;
   logic [2:0] w_rd;
   logic [2:0] w_rm;
   logic [1:0] w_sh;

   assign w_opc = r_ir[15:13];
   assign w_op  = r_ir[12:11];
   assign w_rn  = r_ir[10:8];
   assign w_rd  = r_ir[7:5];
   assign w_sh  = r_ir[4:3];
   assign w_rm  = r_ir[2:0];

   // Instruction class decode
   logic w_is_movi, w_is_movr, w_is_alu, w_is_cmp, w_is_mvn;
   logic w_is_ldr, w_is_str, w_is_halt, w_is_bad;

   assign w_is_movi = (w_opc == 3'b110) && (w_op == 2'b10);
   assign w_is_movr = (w_opc == 3'b110) && (w_op == 2'b00);
   assign w_is_alu  = (w_opc == 3'b101);
   assign w_is_cmp  = w_is_alu && (w_op == 2'b01);
   assign w_is_mvn  = w_is_alu && (w_op == 2'b11);
   assign w_is_ldr  = (w_opc == 3'b011) && (w_op == 2'b00);
   assign w_is_str  = (w_opc == 3'b100) && (w_op == 2'b00);
   assign w_is_halt = (w_opc == 3'b111);
   assign w_is_bad  = !(w_is_movi || w_is_movr || w_is_alu ||
                        w_is_ldr  || w_is_str  || w_is_halt);

   // Only the low byte of the datapath C register forms an address
   logic w_unused_dp_hi;
   assign w_unused_dp_hi = ^bus.dp_out[15:8];

   // ------------------------------------------------------------------
   // State and architectural registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_RST;
         r_pc      <= 8'h00;
         r_ir      <= 16'h0000;
         r_dar     <= 8'h00;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_RST:    r_pc <= bus.start_pc;
            S_LOADIR: begin
               r_ir <= bus.mem_rdata;
               r_pc <= r_pc + 8'd1;
            end
            S_DECODE: if (w_is_bad) r_illegal <= 1'b1;
            S_ADDR:   r_dar <= bus.dp_out[7:0];
            default:  ;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Next state and Moore control decode
   // ------------------------------------------------------------------
   logic [7:0] w_mem_addr;
   logic       w_mem_rd, w_mem_wr, w_write, w_loada, w_loadb, w_loadc;
   logic       w_loads, w_asel, w_bsel, w_halted;
   logic [2:0] w_rnum;
   logic [1:0] w_vsel, w_alu_op, w_shift;

   always_comb begin
      w_next     = r_state;
      w_mem_addr = r_pc;
      w_mem_rd   = 1'b0;
      w_mem_wr   = 1'b0;
      w_rnum     = 3'd0;
      w_vsel     = 2'b00;
      w_write    = 1'b0;
      w_loada    = 1'b0;
      w_loadb    = 1'b0;
      w_loadc    = 1'b0;
      w_loads    = 1'b0;
      w_asel     = 1'b0;
      w_bsel     = 1'b0;
      w_alu_op   = 2'b00;
      w_shift    = 2'b00;
      w_halted   = 1'b0;

      case (r_state)
         S_RST:    w_next = S_FETCH;
         S_FETCH: begin
            w_mem_rd = 1'b1;
            w_next   = S_LOADIR;
         end
         S_LOADIR: w_next = S_DECODE;
         S_DECODE: begin
            if (w_is_movi)                          w_next = S_WRIMM;
            else if (w_is_movr || w_is_mvn)         w_next = S_RDB;
            else if (w_is_alu || w_is_ldr || w_is_str) w_next = S_RDA;
            else                                    w_next = S_HALT; // HALT or illegal
         end
         S_WRIMM: begin
            w_rnum  = w_rn;
            w_vsel  = 2'b01;
            w_write = 1'b1;
            w_next  = S_FETCH;
         end
         S_RDA: begin
            w_rnum  = w_rn;
            w_loada = 1'b1;
            w_next  = (w_is_ldr || w_is_str) ? S_EXEC : S_RDB;
         end
         S_RDB: begin
            w_rnum  = w_rm;
            w_loadb = 1'b1;
            w_next  = S_EXEC;
         end
         S_EXEC: begin
            w_shift = w_sh;
            if (w_is_ldr || w_is_str) begin
               // Effective address = Rn + sximm5
               w_bsel   = 1'b1;
               w_alu_op = 2'b00;
               w_loadc  = 1'b1;
            end else begin
               // MOV-reg reuses ADD with A forced to zero
               w_alu_op = w_op;
               w_asel   = w_is_movr || w_is_mvn;
               if (w_is_cmp) w_loads = 1'b1;
               else          w_loadc = 1'b1;
            end
            if (w_is_cmp)      w_next = S_FETCH;
            else if (w_is_ldr) w_next = S_MEM;
            else if (w_is_str) w_next = S_ADDR;
            else               w_next = S_WB;
         end
         S_WB: begin
            w_rnum  = w_rd;
            w_vsel  = 2'b00;
            w_write = 1'b1;
            w_next  = S_FETCH;
         end
         S_MEM: begin
            w_mem_addr = bus.dp_out[7:0];
            w_mem_rd   = 1'b1;
            w_next     = S_WBM;
         end
         S_WBM: begin
            w_rnum  = w_rd;
            w_vsel  = 2'b10;
            w_write = 1'b1;
            w_next  = S_FETCH;
         end
         S_ADDR:   w_next = S_RDD;
         S_RDD: begin
            w_rnum  = w_rd;
            w_loadb = 1'b1;
            w_next  = S_PASS;
         end
         S_PASS: begin
            // Route Rd through the ALU so C holds the store data
            w_asel   = 1'b1;
            w_loadc  = 1'b1;
            w_alu_op = 2'b00;
            w_shift  = 2'b00;
            w_next   = S_STORE;
         end
         S_STORE: begin
            w_mem_addr = r_dar;
            w_mem_wr   = 1'b1;
            w_next     = S_FETCH;
         end
         S_HALT: begin
            w_halted = 1'b1;
            w_next   = S_HALT;
         end
         default: w_next = S_HALT;
      endcase
   end

   assign bus.mem_addr = w_mem_addr;
   assign bus.mem_rd   = w_mem_rd;
   assign bus.mem_wr   = w_mem_wr;
   assign bus.rnum     = w_rnum;
   assign bus.vsel     = w_vsel;
   assign bus.write    = w_write;
   assign bus.loada    = w_loada;
   assign bus.loadb    = w_loadb;
   assign bus.loadc    = w_loadc;
   assign bus.loads    = w_loads;
   assign bus.asel     = w_asel;
   assign bus.bsel     = w_bsel;
   assign bus.alu_op   = w_alu_op;
   assign bus.shift    = w_shift;
   assign bus.sximm8   = {{8{r_ir[7]}}, r_ir[7:0]};
   assign bus.sximm5   = {{11{r_ir[4]}}, r_ir[4:0]};
   assign bus.pc       = r_pc;
   assign bus.halted   = w_halted;
   assign bus.illegal  = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_sequencer
//  Description : Self-checking bench for cpu_sequencer. Directed programs
//                plus random programs compared against an instruction-level
//                model of cycle counts, memory traffic and register writes.
//  Ports       : none
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_sequencer;
   localparam int MAXC = 512;

   logic clk = 1'b0;
   logic rst = 1'b1;

   cpu_sequencer_if bus ();
   cpu_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Memory with one-cycle read latency; writes are observed, not applied
   logic [15:0] mem [0:255];
   logic [15:0] r_rdata;
   always @(posedge clk) if (bus.mem_rd === 1'b1) r_rdata <= mem[bus.mem_addr];
   assign bus.mem_rdata = r_rdata;

   // Per-cycle trace of the last run (index = cycles after reset release)
   logic [7:0]  t_addr [0:MAXC];
   logic        t_rd   [0:MAXC];
   logic        t_wr   [0:MAXC];
   logic        t_wrt  [0:MAXC];
   logic        t_lda  [0:MAXC];
   logic        t_ldb  [0:MAXC];
   logic        t_ldc  [0:MAXC];
   logic        t_asel [0:MAXC];
   logic        t_bsel [0:MAXC];
   logic [2:0]  t_rnum [0:MAXC];
   logic [1:0]  t_vsel [0:MAXC];
   logic [1:0]  t_alu  [0:MAXC];
   logic [1:0]  t_sh   [0:MAXC];
   logic [15:0] t_sx5  [0:MAXC];
   logic [15:0] t_sx8  [0:MAXC];

   logic [7:0] m_rd [$];
   logic [7:0] m_wr [$];
   logic [4:0] m_rw [$];
   logic [3:0] m_ex [$];
   int cnt_lda, cnt_ldb, cnt_ldc, cnt_lds, cnt_asel, cnt_bsel, both_hi, halt_cyc;

   int n_tests = 0;
   int n_fail  = 0;

   function automatic logic [17:0] strobes();
      return {bus.mem_rd, bus.mem_wr, bus.write, bus.loada, bus.loadb, bus.loadc,
              bus.loads, bus.asel, bus.bsel, bus.rnum, bus.vsel, bus.alu_op, bus.shift};
   endfunction

   task automatic clear_mem();
      for (int k = 0; k < 256; k++) mem[k] = 16'h0000;
   endtask

   // Reset, release and record every cycle until halted (bounded)
   task automatic run_prog(input logic [7:0] spc, input logic [15:0] dp,
                           input int sw_cyc, input logic [15:0] sw_val);
      int cyc;
      bus.start_pc = spc;
      bus.dp_out   = dp;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      m_rd.delete(); m_wr.delete(); m_rw.delete(); m_ex.delete();
      cnt_lda = 0; cnt_ldb = 0; cnt_ldc = 0; cnt_lds = 0;
      cnt_asel = 0; cnt_bsel = 0; both_hi = 0;
      halt_cyc = -1;
      cyc = 0;
      rst = 1'b0;
      while (cyc < MAXC) begin
         @(negedge clk);
         cyc++;
         t_addr[cyc] = bus.mem_addr; t_rd[cyc]  = bus.mem_rd;  t_wr[cyc]   = bus.mem_wr;
         t_wrt[cyc]  = bus.write;    t_lda[cyc] = bus.loada;   t_ldb[cyc]  = bus.loadb;
         t_ldc[cyc]  = bus.loadc;    t_asel[cyc] = bus.asel;   t_bsel[cyc] = bus.bsel;
         t_rnum[cyc] = bus.rnum;     t_vsel[cyc] = bus.vsel;   t_alu[cyc]  = bus.alu_op;
         t_sh[cyc]   = bus.shift;    t_sx5[cyc] = bus.sximm5;  t_sx8[cyc]  = bus.sximm8;
         if (bus.mem_rd)  m_rd.push_back(bus.mem_addr);
         if (bus.mem_wr)  m_wr.push_back(bus.mem_addr);
         if (bus.write)   m_rw.push_back({bus.rnum, bus.vsel});
         if (bus.loadc || bus.loads) m_ex.push_back({bus.alu_op, bus.shift});
         cnt_lda  += int'(bus.loada);
         cnt_ldb  += int'(bus.loadb);
         cnt_ldc  += int'(bus.loadc);
         cnt_lds  += int'(bus.loads);
         cnt_asel += int'(bus.asel);
         cnt_bsel += int'(bus.bsel);
         if (bus.mem_rd && bus.mem_wr) both_hi++;
         if (cyc == 1) bus.start_pc = ~spc;       // must be ignored from now on
         if (cyc == sw_cyc) bus.dp_out = sw_val;
         if (bus.halted === 1'b1) begin
            halt_cyc = cyc;
            break;
         end
      end
      n_tests++;
      if (halt_cyc < 0) begin
         n_fail++;
         $display("FAIL halt_timeout: halted never seen, got none within %0d cycles, want halt", MAXC);
      end
   endtask

   task automatic test_reset();
      bus.start_pc = 8'h5A;
      bus.dp_out   = 16'h1234;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++;
      if (strobes() !== 18'd0) begin
         n_fail++; $display("FAIL reset_strobes: got %h want 0", strobes());
      end
      n_tests++;
      if ({bus.pc, bus.mem_addr, bus.halted, bus.illegal} !== 18'd0) begin
         n_fail++; $display("FAIL reset_pc_addr_flags: got pc=%h addr=%h h=%b i=%b want all 0",
                            bus.pc, bus.mem_addr, bus.halted, bus.illegal);
      end
      n_tests++;
      if ({bus.sximm8, bus.sximm5} !== 32'd0) begin
         n_fail++; $display("FAIL reset_ir: got sximm8=%h sximm5=%h want 0", bus.sximm8, bus.sximm5);
      end
   endtask

   task automatic test_program();
      clear_mem();
      mem[0] = 16'hD005; mem[1] = 16'hD103; mem[2] = 16'hA041; mem[3] = 16'hE000;
      run_prog(8'h00, 16'h0000, -1, 16'h0);
      n_tests++;
      if (halt_cyc !== 19) begin n_fail++; $display("FAIL prog_halt_cycle: got %0d want 19", halt_cyc); end
      n_tests++;
      if (bus.pc !== 8'h04) begin n_fail++; $display("FAIL prog_pc: got %h want 04", bus.pc); end
      n_tests++;
      if (m_rw.size() != 3 || m_rw[0] !== 5'b000_01 || m_rw[1] !== 5'b001_01 || m_rw[2] !== 5'b010_00) begin
         n_fail++; $display("FAIL prog_writes: got %p want {1,5,8}", m_rw);
      end
      n_tests++;
      if (t_sx8[3] !== 16'h0005 || t_wrt[4] !== 1'b1) begin
         n_fail++; $display("FAIL prog_movimm: got sximm8=%h write=%b want 0005 1", t_sx8[3], t_wrt[4]);
      end
      n_tests++;
      if ({t_lda[12], t_rnum[12], t_ldb[13], t_rnum[13]} !== {1'b1, 3'd0, 1'b1, 3'd1}) begin
         n_fail++; $display("FAIL prog_add_reads: got lda=%b rn=%0d ldb=%b rm=%0d want 1 0 1 1",
                            t_lda[12], t_rnum[12], t_ldb[13], t_rnum[13]);
      end
      n_tests++;
      if ({t_ldc[14], t_asel[14], t_bsel[14], t_alu[14], t_sh[14]} !== 7'b100_0000) begin
         n_fail++; $display("FAIL prog_add_exec: got ldc=%b asel=%b bsel=%b alu=%b sh=%b want 1 0 0 00 00",
                            t_ldc[14], t_asel[14], t_bsel[14], t_alu[14], t_sh[14]);
      end
      repeat (3) @(negedge clk);
      n_tests++;
      if ({bus.halted, bus.pc, bus.mem_rd, bus.write} !== {1'b1, 8'h04, 2'b00}) begin
         n_fail++; $display("FAIL prog_halt_hold: got h=%b pc=%h rd=%b wr=%b want 1 04 0 0",
                            bus.halted, bus.pc, bus.mem_rd, bus.write);
      end
   endtask

   task automatic test_start_pc();
      clear_mem();
      mem[8'h10] = 16'hE000;
      run_prog(8'h10, 16'h0000, -1, 16'h0);
      n_tests++;
      if ({t_rd[1], t_addr[1]} !== {1'b1, 8'h10} || halt_cyc !== 4 || bus.pc !== 8'h11) begin
         n_fail++; $display("FAIL start_pc: got rd=%b addr=%h halt=%0d pc=%h want 1 10 4 11",
                            t_rd[1], t_addr[1], halt_cyc, bus.pc);
      end
      n_tests++;
      if (m_rw.size() != 0 || bus.illegal !== 1'b0) begin
         n_fail++; $display("FAIL start_pc_nowrite: got writes=%0d illegal=%b want 0 0", m_rw.size(), bus.illegal);
      end
   endtask

   task automatic test_ldr();
      clear_mem();
      mem[0] = 16'h6062; mem[1] = 16'hE000;      // LDR R3,[R0,#2]; HALT
      run_prog(8'h00, 16'h0007, -1, 16'h0);
      n_tests++;
      if ({t_bsel[5], t_ldc[5], t_alu[5], t_sx5[5]} !== {1'b1, 1'b1, 2'b00, 16'h0002}) begin
         n_fail++; $display("FAIL ldr_exec: got bsel=%b ldc=%b alu=%b sximm5=%h want 1 1 00 0002",
                            t_bsel[5], t_ldc[5], t_alu[5], t_sx5[5]);
      end
      n_tests++;
      if ({t_rd[6], t_wr[6], t_addr[6]} !== {2'b10, 8'h07}) begin
         n_fail++; $display("FAIL ldr_mem: got rd=%b wr=%b addr=%h want 1 0 07", t_rd[6], t_wr[6], t_addr[6]);
      end
      n_tests++;
      if ({t_wrt[7], t_rnum[7], t_vsel[7]} !== {1'b1, 3'd3, 2'b10}) begin
         n_fail++; $display("FAIL ldr_wbm: got write=%b rnum=%0d vsel=%b want 1 3 10", t_wrt[7], t_rnum[7], t_vsel[7]);
      end
      n_tests++;
      if ({t_rd[8], t_addr[8]} !== {1'b1, 8'h01} || halt_cyc !== 11) begin
         n_fail++; $display("FAIL ldr_timing: got rd=%b addr=%h halt=%0d want 1 01 11", t_rd[8], t_addr[8], halt_cyc);
      end
   endtask

   task automatic test_str();
      clear_mem();
      mem[0] = 16'h8221; mem[1] = 16'hE000;      // STR R1,[R2,#1]; HALT
      run_prog(8'h00, 16'h0020, 7, 16'h0055);     // dp_out moves on after ADDR
      n_tests++;
      if ({t_lda[4], t_rnum[4], t_ldb[7], t_rnum[7]} !== {1'b1, 3'd2, 1'b1, 3'd1}) begin
         n_fail++; $display("FAIL str_reads: got lda=%b rn=%0d ldb=%b rd=%0d want 1 2 1 1",
                            t_lda[4], t_rnum[4], t_ldb[7], t_rnum[7]);
      end
      n_tests++;
      if ({t_asel[8], t_ldc[8], t_alu[8], t_sh[8]} !== 6'b11_0000) begin
         n_fail++; $display("FAIL str_pass: got asel=%b ldc=%b alu=%b sh=%b want 1 1 00 00",
                            t_asel[8], t_ldc[8], t_alu[8], t_sh[8]);
      end
      n_tests++;
      if ({t_wr[9], t_rd[9], t_addr[9]} !== {2'b10, 8'h20}) begin
         n_fail++; $display("FAIL str_store: got wr=%b rd=%b addr=%h want 1 0 20", t_wr[9], t_rd[9], t_addr[9]);
      end
      n_tests++;
      if ({t_rd[10], t_addr[10]} !== {1'b1, 8'h01} || halt_cyc !== 13 || m_wr.size() != 1) begin
         n_fail++; $display("FAIL str_timing: got rd=%b addr=%h halt=%0d nwr=%0d want 1 01 13 1",
                            t_rd[10], t_addr[10], halt_cyc, m_wr.size());
      end
   endtask

   task automatic test_wrap_illegal();
      clear_mem();
      run_prog(8'hFF, 16'h0000, -1, 16'h0);
      n_tests++;
      if ({t_addr[1], bus.pc} !== {8'hFF, 8'h00}) begin
         n_fail++; $display("FAIL wrap_pc: got fetch=%h pc=%h want FF 00", t_addr[1], bus.pc);
      end
      n_tests++;
      if ({bus.illegal, bus.halted} !== 2'b11 || halt_cyc !== 4) begin
         n_fail++; $display("FAIL wrap_illegal: got illegal=%b halted=%b cyc=%0d want 1 1 4",
                            bus.illegal, bus.halted, halt_cyc);
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      int hc;
      clear_mem();
      mem[8'h30] = 16'hD005; mem[8'h31] = 16'hD103; mem[8'h32] = 16'hA041; mem[8'h33] = 16'hE000;
      bus.start_pc = 8'h30;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (13) @(negedge clk);                // ADD is in RDB now
      n_tests++;
      if ({bus.loadb, bus.rnum} !== {1'b1, 3'd1}) begin
         n_fail++; $display("FAIL midrst_pre: got loadb=%b rnum=%0d want 1 1", bus.loadb, bus.rnum);
      end
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (strobes() !== 18'd0 || bus.pc !== 8'h00) begin
         n_fail++; $display("FAIL midrst_abort: got strobes=%h pc=%h want 0 00", strobes(), bus.pc);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({bus.mem_rd, bus.mem_addr, bus.pc} !== {1'b1, 8'h30, 8'h30}) begin
         n_fail++; $display("FAIL midrst_restart: got rd=%b addr=%h pc=%h want 1 30 30",
                            bus.mem_rd, bus.mem_addr, bus.pc);
      end
      cyc = 1;
      hc  = -1;
      while (cyc < 60) begin
         if (bus.halted === 1'b1) begin
            hc = cyc;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      n_tests++;
      if (hc !== 19) begin n_fail++; $display("FAIL midrst_rerun: got halt cycle %0d want 19", hc); end
   endtask

   // Random programs against an instruction-level model
   task automatic test_random(input int iters);
      logic [7:0]  spc, p;
      logic [15:0] dp, ins;
      logic [2:0]  rn, rd, rm;
      logic [1:0]  sh;
      logic [4:0]  im5;
      logic [7:0]  im8;
      int          n, cls, e_cyc, e_lda, e_ldb, e_ldc, e_lds, e_asel, e_bsel;
      logic        e_ill, bad;
      logic [7:0]  e_rd [$];
      logic [7:0]  e_wr [$];
      logic [4:0]  e_rw [$];
      logic [3:0]  e_ex [$];
      for (int it = 0; it < iters; it++) begin
         clear_mem();
         e_rd.delete(); e_wr.delete(); e_rw.delete(); e_ex.delete();
         e_lda = 0; e_ldb = 0; e_ldc = 0; e_lds = 0; e_asel = 0; e_bsel = 0;
         spc   = 8'($urandom_range(0, 127));
         dp    = 16'($urandom) | 16'h0080;
         n     = $urandom_range(1, 10);
         p     = spc;
         e_cyc = 1;
         for (int i = 0; i < n; i++) begin
            cls = $urandom_range(0, 7);
            rn = 3'($urandom); rd = 3'($urandom); rm = 3'($urandom);
            sh = 2'($urandom); im5 = 5'($urandom); im8 = 8'($urandom);
            e_rd.push_back(p);
            case (cls)
               0: begin ins = {3'b110, 2'b10, rn, im8}; e_cyc += 4; e_rw.push_back({rn, 2'b01}); end
               1: begin ins = {3'b110, 2'b00, rn, rd, sh, rm}; e_cyc += 6; e_ldb++; e_ldc++; e_asel++;
                        e_rw.push_back({rd, 2'b00}); e_ex.push_back({2'b00, sh}); end
               2: begin ins = {3'b101, 2'b00, rn, rd, sh, rm}; e_cyc += 7; e_lda++; e_ldb++; e_ldc++;
                        e_rw.push_back({rd, 2'b00}); e_ex.push_back({2'b00, sh}); end
               3: begin ins = {3'b101, 2'b01, rn, rd, sh, rm}; e_cyc += 6; e_lda++; e_ldb++; e_lds++;
                        e_ex.push_back({2'b01, sh}); end
               4: begin ins = {3'b101, 2'b10, rn, rd, sh, rm}; e_cyc += 7; e_lda++; e_ldb++; e_ldc++;
                        e_rw.push_back({rd, 2'b00}); e_ex.push_back({2'b10, sh}); end
               5: begin ins = {3'b101, 2'b11, rn, rd, sh, rm}; e_cyc += 6; e_ldb++; e_ldc++; e_asel++;
                        e_rw.push_back({rd, 2'b00}); e_ex.push_back({2'b11, sh}); end
               6: begin ins = {3'b011, 2'b00, rn, rd, im5}; e_cyc += 7; e_lda++; e_ldc++; e_bsel++;
                        e_rd.push_back(dp[7:0]); e_rw.push_back({rd, 2'b10});
                        e_ex.push_back({2'b00, im5[4:3]}); end
               default: begin ins = {3'b100, 2'b00, rn, rd, im5}; e_cyc += 9; e_lda++; e_ldb++;
                        e_ldc += 2; e_bsel++; e_asel++; e_wr.push_back(dp[7:0]);
                        e_ex.push_back({2'b00, im5[4:3]}); e_ex.push_back(4'b0000); end
            endcase
            mem[p] = ins;
            p = p + 8'd1;
         end
         e_rd.push_back(p);
         e_ill = ($urandom_range(0, 3) == 0);
         if (e_ill) begin
            case ($urandom_range(0, 3))
               0: ins = {3'($urandom_range(0, 2)), 13'($urandom)};
               1: ins = {3'b110, 1'($urandom), 1'b1, 11'($urandom)};
               2: ins = {3'b011, 2'($urandom_range(1, 3)), 11'($urandom)};
               default: ins = {3'b100, 2'($urandom_range(1, 3)), 11'($urandom)};
            endcase
         end else begin
            ins = {3'b111, 13'($urandom)};
         end
         mem[p] = ins;
         p = p + 8'd1;
         e_cyc += 3;

         run_prog(spc, dp, -1, 16'h0);

         n_tests++;
         if (halt_cyc !== e_cyc || bus.pc !== p || bus.illegal !== e_ill) begin
            n_fail++; $display("FAIL rand_end it=%0d: got cyc=%0d pc=%h ill=%b want %0d %h %b",
                               it, halt_cyc, bus.pc, bus.illegal, e_cyc, p, e_ill);
         end
         n_tests++;
         bad = (m_rd.size() != e_rd.size());
         for (int k = 0; !bad && k < e_rd.size(); k++) if (m_rd[k] !== e_rd[k]) bad = 1'b1;
         if (bad) begin n_fail++; $display("FAIL rand_reads it=%0d: got %p want %p", it, m_rd, e_rd); end
         n_tests++;
         bad = (m_wr.size() != e_wr.size());
         for (int k = 0; !bad && k < e_wr.size(); k++) if (m_wr[k] !== e_wr[k]) bad = 1'b1;
         if (bad) begin n_fail++; $display("FAIL rand_memwr it=%0d: got %p want %p", it, m_wr, e_wr); end
         n_tests++;
         bad = (m_rw.size() != e_rw.size());
         for (int k = 0; !bad && k < e_rw.size(); k++) if (m_rw[k] !== e_rw[k]) bad = 1'b1;
         if (bad) begin n_fail++; $display("FAIL rand_regwr it=%0d: got %p want %p", it, m_rw, e_rw); end
         n_tests++;
         bad = (m_ex.size() != e_ex.size());
         for (int k = 0; !bad && k < e_ex.size(); k++) if (m_ex[k] !== e_ex[k]) bad = 1'b1;
         if (bad) begin n_fail++; $display("FAIL rand_aluop it=%0d: got %p want %p", it, m_ex, e_ex); end
         n_tests++;
         if ({cnt_lda, cnt_ldb, cnt_ldc, cnt_lds, cnt_asel, cnt_bsel, both_hi} !==
             {e_lda, e_ldb, e_ldc, e_lds, e_asel, e_bsel, 32'd0}) begin
            n_fail++; $display("FAIL rand_strobes it=%0d: got a%0d b%0d c%0d s%0d as%0d bs%0d both%0d want a%0d b%0d c%0d s%0d as%0d bs%0d both0",
                               it, cnt_lda, cnt_ldb, cnt_ldc, cnt_lds, cnt_asel, cnt_bsel, both_hi,
                               e_lda, e_ldb, e_ldc, e_lds, e_asel, e_bsel);
         end
      end
   endtask

   initial begin
      bus.start_pc = 8'h00;
      bus.dp_out   = 16'h0000;
      test_reset();
      test_program();
      test_start_pc();
      test_ldr();
      test_str();
      test_wrap_illegal();
      test_reset_mid();
      test_random(40);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cpu_sequencer.md
# cpu_sequencer

Fetch/decode/execute controller for the 16-bit simple RISC CPU. It owns the 8-bit program counter and the instruction register. It arbitrates the single-port 256×16 instruction/data memory between instruction fetch and LDR/STR accesses. It drives the register-file/ALU datapath control strobes one state per cycle until a HALT instruction is retired.

## Interface
- No parameters (PC width 8, instruction width 16, fixed).
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start_pc  in  8  PC loaded on the first clock after reset release
- mem_rdata  in  16  memory read data, valid the cycle after mem_rd
- dp_out  in  16  datapath C register (address source for LDR/STR)
- mem_addr  out  8  memory address
- mem_rd / mem_wr  out  1  memory read / write strobes, never both high
- rnum  out  3  register-file read/write index
- vsel  out  2  writeback source: 00 C, 01 sximm8, 10 mem_rdata
- write, loada, loadb, loadc, loads  out  1  datapath load strobes
- asel, bsel  out  1  asel=1 forces A operand to 0; bsel=1 selects sximm5 for B
- alu_op, shift  out  2  ALU op (00 ADD, 01 CMP, 10 AND, 11 MVN), shifter code from ir[4:3]
- sximm8, sximm5  out  16  sign-extended ir[7:0], ir[4:0]
- pc  out  8  current PC
- halted, illegal  out  1  sticky status flags

## Operation
- Encoding: ir[15:13] opcode, ir[12:11] op, ir[10:8] Rn, ir[7:5] Rd, ir[4:3] shift, ir[2:0] Rm.
- Instruction classes:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{sh}
  - 101/xx ALU by op
  - 011/00 LDR Rd,[Rn,#imm5]
  - 100/00 STR Rd,[Rn,#imm5]
  - 111/xx HALT
  - Anything else is illegal: set illegal=1 and halted=1, then go to HALT.
- Control outputs are Moore decodes of state plus ir. Any strobe not listed for a state is 0.
- States and actions:
  - RST: pc<=start_pc → FETCH
  - FETCH: mem_addr=pc, mem_rd=1 → LOADIR
  - LOADIR: ir<=mem_rdata; pc<=pc+1 (8-bit wrap, 0xFF→0x00) → DECODE
  - DECODE: no strobes; branch by class
  - WRIMM: rnum=Rn, vsel=01, write → FETCH
  - RDA: rnum=Rn, loada
  - RDB: rnum=Rm, loadb
  - EXEC: loadc, shift, alu_op. MOV-reg and MVN set asel=1. LDR/STR set bsel=1 and alu_op=ADD. CMP asserts loads only, with no loadc.
  - WB: rnum=Rd, vsel=00, write → FETCH
  - MEM: mem_addr=dp_out[7:0], mem_rd → WBM
  - WBM: rnum=Rd, vsel=10, write → FETCH
  - ADDR: dar<=dp_out[7:0] → RDD
  - RDD: rnum=Rd, loadb → PASS
  - PASS: asel=1, loadc, alu_op=ADD, shift=00 → STORE
  - STORE: mem_addr=dar, mem_wr → FETCH. The datapath drives write data from C.
  - HALT: halted=1, all strobes 0, mem_addr=pc; holds until rst.
- State paths:
  - MOV imm: WRIMM
  - MOV reg / MVN: RDB→EXEC→WB
  - ADD/AND: RDA→RDB→EXEC→WB
  - CMP: RDA→RDB→EXEC→FETCH
  - LDR: RDA→EXEC→MEM→WBM
  - STR: RDA→EXEC→ADDR→RDD→PASS→STORE

## Timing
- Reset values:
  - state RST; pc=0x00, ir=0x0000, dar=0x00
  - mem_addr=0x00; mem_rd, mem_wr, and all strobes 0
  - halted=0, illegal=0
- Reset is asynchronous. Assertion mid-instruction aborts it immediately, with no mem_wr glitch after assertion.
- Cycles from FETCH to next FETCH:
  - MOV imm: 4
  - MOV reg / MVN / CMP: 6
  - ADD/AND: 7
  - LDR: 7
  - STR: 9
  - HALT: reaches HALT 3 cycles after FETCH
- Memory read latency is exactly 1 cycle. mem_rdata is sampled only in LOADIR and WBM.
- start_pc is sampled only in RST. Later changes are ignored.

## Test plan
- Program with start_pc=0x00:
  - mem[0]=MOV R0,#5 (0xD005), mem[1]=MOV R1,#3 (0xD103), mem[2]=ADD R2,R0,R1 (0xA041), mem[3]=HALT (0xE000)
  - halted=1 exactly 1+4+4+7+3=19 cycles after reset release; pc=0x04
  - Three write pulses with rnum 0, 1, 2 in that order.
- start_pc=0x10, mem[0x10]=HALT: first mem_addr in FETCH is 0x10, halted after 4 cycles, pc=0x11, no write.
- LDR R3,[R0,#2] with dp_out=0x0007 in MEM: mem_rd with mem_addr=0x07; next cycle write with rnum=3, vsel=10.
- STR sequence: dar latched from dp_out=0x20. STORE cycle shows mem_wr=1, mem_addr=0x20, mem_rd=0. Total 9 cycles.
- start_pc=0xFF: the fetched instruction at 0xFF increments pc to 0x00 (wrap). ir=0x0000 (opcode 000) then sets illegal=1 and halted=1.
- rst asserted during RDB of an ADD: all strobes 0 the same cycle, pc=0x00. After release, pc=start_pc and the fetch restarts from it.
